// File: rtl/alu_exec_stage.sv
// EX-stage execution unit: decodes the 3-bit ALU control code, computes the
// result and queues it, with its flags, in a 2-entry FIFO toward MEM/branch
// logic. Also counts back-pressure stall cycles (saturating).
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_cntr,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    // Queue storage (no reset needed: an entry is only read after being written)
    logic [WIDTH-1:0] res_mem_q  [2];
    logic             zero_mem_q [2];
    logic             ill_mem_q  [2];

    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Registered head view so outputs hold their last value once the queue drains
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             alu_zero;
    logic             push;
    logic             pop;
    logic             wr_en;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;

    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_q;

    // ALU datapath; code 7 and any unknown bit fall to the illegal default
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALU_cntr)
            3'd0: alu_res = src_a + src_b;
            3'd1: alu_res = src_a - src_b;
            3'd2: alu_res = src_a & src_b;
            3'd3: alu_res = src_a | src_b;
            3'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'd5: alu_res = src_a ^ src_b;
            3'd6: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    assign alu_zero = (alu_res == '0);

    // Pointer, occupancy, stall counter and head-view next state
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        stall_d   = stall_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        if (!flush && out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};

        // Next head may be the entry being written this very edge: bypass it
        if (count_d != 2'd0) begin
            if (wr_en && (tail_q == head_d)) begin
                result_d  = alu_res;
                zero_d    = alu_zero;
                illegal_d = alu_ill;
            end else begin
                result_d  = res_mem_q[head_d];
                zero_d    = zero_mem_q[head_d];
                illegal_d = ill_mem_q[head_d];
            end
        end
    end

    // Control and output registers, cleared immediately by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            stall_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // One write port per queue slot, selected by the tail pointer
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic SLOT = 1'(gi);
            // Capture result and flags at push time
            always_ff @(posedge clk) begin
                if (wr_en && (tail_q == SLOT)) begin
                    res_mem_q[gi]  <= alu_res;
                    zero_mem_q[gi] <= alu_zero;
                    ill_mem_q[gi]  <= alu_ill;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a model predicts each result at push
// time, the queue is compared in order as results are consumed. A second
// instance with CNT_W=2 shares all inputs to exercise stall saturation.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  alu_cntr;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_zero, s_illegal;
    logic [31:0] s_result;
    logic [1:0]  s_stall_cnt;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   stall_m  = 0;
    int   stall_s  = 0;

    alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_cntr(alu_cntr), .src_a(a), .src_b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    alu_exec_stage #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .ALU_cntr(alu_cntr), .src_a(a), .src_b(b), .out_valid(s_out_valid),
        .out_ready(out_ready), .result(s_result), .zero(s_zero), .illegal(s_illegal),
        .stall_cnt(s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.res = '0;
        e.ill = 1'b0;
        if ($isunknown(c) || c == 3'd7) begin
            e.ill = 1'b1;
        end else begin
            case (c)
                3'd0: e.res = x + y;
                3'd1: e.res = x - y;
                3'd2: e.res = x & y;
                3'd3: e.res = x | y;
                3'd4: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                3'd5: e.res = x ^ y;
                3'd6: e.res = (x < y) ? 32'd1 : 32'd0;
                default: e.res = '0;
            endcase
        end
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Check handshake/status before the edge, update the model, advance one cycle
    task automatic tick();
        exp_t e;
        bit   do_push;
        bit   do_pop;
        #2;
        check_val("in_ready", {63'd0, in_ready}, {63'd0, (sb.size() != 2)});
        check_val("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
        check_val("stall_cnt", {48'd0, stall_cnt}, 64'(stall_m));
        check_val("stall_cnt_w2", {62'd0, s_stall_cnt}, 64'(stall_s));
        do_push = in_valid && (sb.size() != 2);
        do_pop  = out_ready && (sb.size() != 0);
        if (!flush && sb.size() != 0 && !out_ready) begin
            if (stall_m < 65535) stall_m++;
            if (stall_s < 3) stall_s++;
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                e = sb.pop_front();
                check_val("result", {32'd0, result}, {32'd0, e.res});
                check_val("zero", {63'd0, zero}, {63'd0, e.z});
                check_val("illegal", {63'd0, illegal}, {63'd0, e.ill});
                $display("pop  result=0x%08h zero=%0d illegal=%0d", result, zero, illegal);
            end
            if (do_push) begin
                sb.push_back(model(alu_cntr, a, b));
                $display("push op=%b a=0x%08h b=0x%08h", alu_cntr, a, b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        alu_cntr = c;
        a        = x;
        b        = y;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [2:0] code_unk;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_cntr  = 3'd0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_result", {32'd0, result}, 64'd0);
        check_val("rst_zero", {63'd0, zero}, 64'd0);
        check_val("rst_illegal", {63'd0, illegal}, 64'd0);
        check_val("rst_stall", {48'd0, stall_cnt}, 64'd0);
        rst = 1'b0;

        // Streaming arithmetic, one result per cycle
        out_ready = 1'b1;
        op(3'd0, 32'd7, 32'd5);
        op(3'd1, 32'd3, 32'd5);
        op(3'd4, 32'hFFFF_FFFF, 32'd1);
        op(3'd6, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        // zero flag, bitwise ops, signed/unsigned boundaries
        op(3'd1, 32'd9, 32'd9);
        op(3'd5, 32'h0000_00F0, 32'h0000_000F);
        op(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
        op(3'd3, 32'hFF00_0000, 32'h0000_00FF);
        op(3'd4, 32'h7FFF_FFFF, 32'h8000_0000);
        op(3'd6, 32'h7FFF_FFFF, 32'h8000_0000);
        op(3'd0, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        // Back-pressure: third push refused, stall cycles counted, then drain
        out_ready = 1'b0;
        op(3'd0, 32'd1, 32'd1);
        op(3'd0, 32'd2, 32'd2);
        op(3'd0, 32'd3, 32'd3);
        idle(5);
        out_ready = 1'b1;
        idle(3);

        // Asynchronous reset in the middle of a cycle with a full queue
        out_ready = 1'b0;
        op(3'd5, 32'hAAAA_5555, 32'h1234_5678);
        op(3'd0, 32'd40, 32'd2);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("arst_stall", {48'd0, stall_cnt}, 64'd0);
        check_val("arst_stall_w2", {62'd0, s_stall_cnt}, 64'd0);
        sb.delete();
        stall_m = 0;
        stall_s = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Flush with simultaneous push and pop while one entry is queued
        out_ready = 1'b0;
        op(3'd0, 32'd1, 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        op(3'd0, 32'd100, 32'd200);
        flush = 1'b0;
        idle(1);
        op(3'd2, 32'h0000_FF00, 32'h0000_0FF0);
        idle(2);

        // Illegal codes, then long stall to saturate the narrow counter
        code_unk  = 3'bx01;
        out_ready = 1'b1;
        op(3'b111, 32'd5, 32'd5);
        op(code_unk, 32'd5, 32'd3);
        idle(2);
        out_ready = 1'b0;
        op(3'b111, 32'd9, 32'd1);
        idle(6);
        out_ready = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
